// File: rtl/mfcc_pkg.sv
// Shared constants, FSM state type and elaboration-time table generators for the MFCC DCT.
// The lifter constants here are only consumed when MFCC_DCT_LIFTER_EN is defined.
package mfcc_pkg;

  localparam int unsigned DEF_NUM_FILTERS = 26;
  localparam int unsigned DEF_NUM_COEFFS  = 12;
  localparam int unsigned DATA_W          = 32;
  localparam int unsigned Q_COS           = 14;
  localparam int unsigned Q_LIFT          = 12;
  localparam int unsigned LIFT_W          = 18;
  localparam int unsigned LIFT_GAIN       = 11;
  localparam int unsigned LIFT_DEN        = 22;
  localparam real         PI              = 3.14159265358979323846;

  typedef enum logic [1:0] {
    S_FILL    = 2'd0,
    S_COMPUTE = 2'd1,
    S_EMIT    = 2'd2,
    S_LIFT    = 2'd3
  } state_t;

  function automatic int round_real(input real r);
    if (r >= 0.0) return $rtoi(r + 0.5);
    else          return -$rtoi(0.5 - r);
  endfunction

  // round(2^Q_COS * cos(pi*num/den)); folded into the first quadrant so the series converges fast
  function automatic int cos_q14(input int unsigned num, input int unsigned den);
    int unsigned a;
    logic        neg;
    real         x, term, sum;
    a = num % (2 * den);
    if (a > den) a = 2 * den - a;
    neg = 1'b0;
    if (2 * a > den) begin
      neg = 1'b1;
      a   = den - a;
    end
    x    = PI * real'(a) / real'(den);
    term = 1.0;
    sum  = 1.0;
    for (int i = 1; i < 16; i++) begin
      term = -term * x * x / real'((2 * i - 1) * (2 * i));
      sum  = sum + term;
    end
    if (neg) sum = -sum;
    return round_real(real'(32'd1 << Q_COS) * sum);
  endfunction

  // round(2^Q_LIFT * (1 + 11*sin(pi*k/22)))
  function automatic int lifter_q12(input int unsigned k);
    real x, term, sum;
    x    = PI * real'(k) / real'(LIFT_DEN);
    term = x;
    sum  = x;
    for (int i = 1; i < 16; i++) begin
      term = -term * x * x / real'((2 * i) * (2 * i + 1));
      sum  = sum + term;
    end
    return round_real(real'(32'd1 << Q_LIFT) * (1.0 + real'(LIFT_GAIN) * sum));
  endfunction

  function automatic logic signed [DATA_W-1:0] sat32(input logic signed [63:0] v);
    if (v > 64'sh0000_0000_7FFF_FFFF)       return 32'sh7FFF_FFFF;
    else if (v < -64'sh0000_0000_8000_0000) return 32'sh8000_0000;
    else                                    return 32'(v);
  endfunction

endpackage

// File: rtl/dct_cos_rom.sv
// Constant DCT-II cosine table C[k][n] in Q1.14, combinational lookup by (k, n).
module dct_cos_rom
  import mfcc_pkg::*;
#(
  parameter int unsigned NUM_FILTERS = DEF_NUM_FILTERS,
  parameter int unsigned NUM_COEFFS  = DEF_NUM_COEFFS,
  parameter int unsigned COS_WIDTH   = 16
) (
  input  logic [$clog2(NUM_COEFFS+1)-1:0] k,
  input  logic [$clog2(NUM_FILTERS)-1:0]  n,
  output logic signed [COS_WIDTH-1:0]     coef_c
);

  logic signed [COS_WIDTH-1:0] rom [NUM_COEFFS+1][NUM_FILTERS];

  // Row 0 is filled for uniform indexing by k; it is never addressed.
  for (genvar gk = 0; gk <= NUM_COEFFS; gk++) begin : g_row
    for (genvar gn = 0; gn < NUM_FILTERS; gn++) begin : g_col
      assign rom[gk][gn] = COS_WIDTH'(cos_q14(gk * (2 * gn + 1), 2 * NUM_FILTERS));
    end
  end

  assign coef_c = rom[k][n];

endmodule

// File: rtl/mfcc_dct.sv
// DCT-II of a frame of log mel energies into MFCC coefficients k = 1..NUM_COEFFS.
// Define MFCC_DCT_LIFTER_EN to add a sinusoidal cepstral lifter stage (one extra cycle).
module mfcc_dct
  import mfcc_pkg::*;
#(
  parameter int unsigned NUM_FILTERS = DEF_NUM_FILTERS,
  parameter int unsigned NUM_COEFFS  = DEF_NUM_COEFFS,
  parameter int unsigned COS_WIDTH   = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] log_data_in,
  input  logic        log_valid_in,
  output logic        log_ready_out,
  output logic [31:0] mfcc_data_out,
  output logic        mfcc_valid_out,
  input  logic        mfcc_ready_in,
  output logic        mfcc_last_out
);

  localparam int unsigned KW     = $clog2(NUM_COEFFS + 1);
  localparam int unsigned NW     = $clog2(NUM_FILTERS);
  localparam int unsigned PROD_W = DATA_W + COS_WIDTH;
  localparam int unsigned ACC_W  = PROD_W + $clog2(NUM_FILTERS);

  state_t                   state;
  logic [NW-1:0]            n;
  logic [KW-1:0]            k;
  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W-1:0] fbuf [NUM_FILTERS];

  logic signed [COS_WIDTH-1:0] cos_c;
  logic signed [PROD_W-1:0]    prod_c;
  logic signed [ACC_W-1:0]     acc_sum_c;
  logic signed [DATA_W-1:0]    coef_sat_c;

  // Frame buffer; contents are don't-care after reset.
  always_ff @(posedge clk_in) begin
    if (log_valid_in && log_ready_out) fbuf[n] <= log_data_in;
  end

  dct_cos_rom #(
    .NUM_FILTERS(NUM_FILTERS),
    .NUM_COEFFS (NUM_COEFFS),
    .COS_WIDTH  (COS_WIDTH)
  ) u_rom (
    .k     (k),
    .n     (n),
    .coef_c(cos_c)
  );

  // Full-precision MAC; the final sum is taken straight from the adder on the last tap.
  assign prod_c     = PROD_W'(fbuf[n]) * PROD_W'(cos_c);
  assign acc_sum_c  = acc + ACC_W'(prod_c);
  assign coef_sat_c = sat32(64'(acc_sum_c >>> Q_COS));

`ifdef MFCC_DCT_LIFTER_EN
  logic signed [LIFT_W-1:0] lift_tab [NUM_COEFFS+1];
  logic signed [DATA_W-1:0] lift_stage;
  logic signed [DATA_W-1:0] lift_c;

  for (genvar gk = 0; gk <= NUM_COEFFS; gk++) begin : g_lift
    assign lift_tab[gk] = LIFT_W'(lifter_q12(gk));
  end

  assign lift_c = sat32((64'(lift_stage) * 64'(lift_tab[k])) >>> Q_LIFT);
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state          <= S_FILL;
      n              <= '0;
      k              <= KW'(1);
      acc            <= '0;
      log_ready_out  <= 1'b0;
      mfcc_data_out  <= '0;
      mfcc_valid_out <= 1'b0;
      mfcc_last_out  <= 1'b0;
`ifdef MFCC_DCT_LIFTER_EN
      lift_stage     <= '0;
`endif
    end else begin
      case (state)
        S_FILL: begin
          log_ready_out <= 1'b1;
          if (log_valid_in && log_ready_out) begin
            if (n == NW'(NUM_FILTERS - 1)) begin
              n             <= '0;
              log_ready_out <= 1'b0;
              state         <= S_COMPUTE;
            end else begin
              n <= n + NW'(1);
            end
          end
        end

        S_COMPUTE: begin
          if (n == NW'(NUM_FILTERS - 1)) begin
            n   <= '0;
            acc <= '0;
`ifdef MFCC_DCT_LIFTER_EN
            lift_stage     <= coef_sat_c;
            state          <= S_LIFT;
`else
            mfcc_data_out  <= coef_sat_c;
            mfcc_valid_out <= 1'b1;
            mfcc_last_out  <= (k == KW'(NUM_COEFFS));
            state          <= S_EMIT;
`endif
          end else begin
            n   <= n + NW'(1);
            acc <= acc_sum_c;
          end
        end

`ifdef MFCC_DCT_LIFTER_EN
        S_LIFT: begin
          mfcc_data_out  <= lift_c;
          mfcc_valid_out <= 1'b1;
          mfcc_last_out  <= (k == KW'(NUM_COEFFS));
          state          <= S_EMIT;
        end
`endif

        S_EMIT: begin
          if (mfcc_ready_in) begin
            mfcc_valid_out <= 1'b0;
            mfcc_last_out  <= 1'b0;
            if (k < KW'(NUM_COEFFS)) begin
              k     <= k + KW'(1);
              state <= S_COMPUTE;
            end else begin
              k             <= KW'(1);
              log_ready_out <= 1'b1;
              state         <= S_FILL;
            end
          end
        end

        default: state <= S_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_mfcc_dct.sv
// Directed self-checking bench for mfcc_dct (26 filters, 12 coefficients).
module tb_mfcc_dct;

  localparam int NF = 26;
  localparam int NC = 12;
`ifdef MFCC_DCT_LIFTER_EN
  localparam int LAT = NF + 2;
  localparam int LIM = 64 * 12;
`else
  localparam int LAT = NF + 1;
  localparam int LIM = 64;
`endif

  // 4 * round(16384*cos(pi*k/52)), k = 1..12
  localparam logic [31:0] IMP_EXP [NC] = '{
    32'd65416, 32'd65060, 32'd64464, 32'd63632, 32'd62568, 32'd61276,
    32'd59764, 32'd58028, 32'd56084, 32'd53936, 32'd51588, 32'd49056
  };

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] log_data;
  logic        log_valid;
  logic        log_ready;
  logic [31:0] mfcc_data;
  logic        mfcc_valid;
  logic        mfcc_ready;
  logic        mfcc_last;

  always #5 clk = ~clk;

  mfcc_dct #(
    .NUM_FILTERS(NF),
    .NUM_COEFFS (NC),
    .COS_WIDTH  (16)
  ) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .log_data_in   (log_data),
    .log_valid_in  (log_valid),
    .log_ready_out (log_ready),
    .mfcc_data_out (mfcc_data),
    .mfcc_valid_out(mfcc_valid),
    .mfcc_ready_in (mfcc_ready),
    .mfcc_last_out (mfcc_last)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] frame [NF];
  logic [31:0] got [NC];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_frame(input logic [31:0] lo, input logic [31:0] hi, input int split);
    for (int i = 0; i < NF; i++) frame[i] = (i < split) ? lo : hi;
  endtask

  // Offer frame[0..count-1]; returns #1 after the last handshake edge.
  task automatic send_frame(input int count);
    for (int i = 0; i < count; i++) begin
      int w = 0;
      log_data  = frame[i];
      log_valid = 1'b1;
      @(negedge clk);
      while (!log_ready && w < 200) begin
        @(negedge clk);
        w++;
      end
      if (!log_ready) begin
        check("in_ready", 32'(log_ready), 32'd1);
        break;
      end
      @(posedge clk);
      #1;
    end
    log_valid = 1'b0;
  endtask

  // Cycle 1 is the one right after the last input handshake.
  task automatic check_latency(input string tag);
    int cyc = 1;
    while (!mfcc_valid && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check(tag, 32'(cyc), 32'(LAT));
  endtask

  task automatic get_coef(output logic [31:0] d, output logic l);
    int w = 0;
    while (!mfcc_valid && w < 200) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (!mfcc_valid) begin
      check("out_valid", 32'(mfcc_valid), 32'd1);
      d = '0;
      l = 1'b0;
      return;
    end
    d = mfcc_data;
    l = mfcc_last;
    @(posedge clk);
    #1;
  endtask

  task automatic collect(input string tag, input int from_k);
    logic [31:0] d;
    logic        l;
    for (int j = from_k - 1; j < NC; j++) begin
      get_coef(d, l);
      got[j] = d;
      check($sformatf("%s_last_k%0d", tag, j + 1), 32'(l), 32'(j == NC - 1));
    end
  endtask

  task automatic check_impulse(input string tag, input int from_k);
    for (int j = from_k - 1; j < NC; j++) begin
`ifdef MFCC_DCT_LIFTER_EN
      if (j == 0) check($sformatf("%s_k1", tag), got[0], 32'd167820);
`else
      check($sformatf("%s_k%0d", tag, j + 1), got[j], IMP_EXP[j]);
`endif
    end
  endtask

  initial begin
    logic [31:0] d3;
    logic [31:0] exp3;
    logic        l3;
    int          seen;

    rst        = 1'b1;
    log_valid  = 1'b0;
    log_data   = '0;
    mfcc_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(mfcc_valid), 32'd0);
    check("rst_last", 32'(mfcc_last), 32'd0);
    check("rst_data", mfcc_data, 32'd0);
    check("rst_ready", 32'(log_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_rst", 32'(log_ready), 32'd1);

    // All-zero frame
    set_frame(32'h0, 32'h0, NF);
    send_frame(NF);
    check_latency("zero_latency");
    collect("zero", 1);
    for (int j = 0; j < NC; j++) check($sformatf("zero_k%0d", j + 1), got[j], 32'h0);

    // Impulse at n = 0
    set_frame(32'h0001_0000, 32'h0, 1);
    send_frame(NF);
    check_latency("imp_latency");
    collect("imp", 1);
    check_impulse("imp", 1);

    // Constant input: DCT of a DC vector is zero up to table rounding
    set_frame(32'h0001_0000, 32'h0001_0000, NF);
    send_frame(NF);
    collect("dc", 1);
    for (int j = 0; j < NC; j++) begin
      logic signed [31:0] s;
      logic signed [31:0] a;
      s = got[j];
      a = (s < 0) ? -s : s;
      check($sformatf("dc_small_k%0d", j + 1), 32'(a <= LIM), 32'd1);
    end

    // Output back-pressure on k = 3
    set_frame(32'h0001_0000, 32'h0, 1);
    send_frame(NF);
    collect_two: begin
      logic [31:0] d;
      logic        l;
      get_coef(d, l);
      get_coef(d, l);
    end
    mfcc_ready = 1'b0;
    seen = 0;
    while (!mfcc_valid && seen < 200) begin
      @(posedge clk);
      #1;
      seen++;
    end
    d3 = mfcc_data;
    l3 = mfcc_last;
`ifdef MFCC_DCT_LIFTER_EN
    exp3 = d3;
`else
    exp3 = IMP_EXP[2];
    check("stall_k3_value", d3, exp3);
`endif
    check("stall_k3_last", 32'(l3), 32'd0);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("stall_data_c%0d", c), mfcc_data, exp3);
      check($sformatf("stall_valid_c%0d", c), 32'(mfcc_valid), 32'd1);
      check($sformatf("stall_last_c%0d", c), 32'(mfcc_last), 32'd0);
      check($sformatf("stall_inready_c%0d", c), 32'(log_ready), 32'd0);
    end
    mfcc_ready = 1'b1;
    @(posedge clk);
    #1;
    collect("stall", 4);
    check_impulse("stall", 4);

    // Reset in the middle of filling discards the partial frame
    set_frame(32'h0001_0000, 32'h0, 1);
    send_frame(13);
    rst = 1'b1;
    #1;
    check("midrst_ready", 32'(log_ready), 32'd0);
    check("midrst_valid", 32'(mfcc_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (mfcc_valid) seen++;
    end
    check("midrst_no_output", 32'(seen), 32'd0);
    send_frame(NF);
    check_latency("midrst_latency");
    collect("midrst", 1);
    check_impulse("midrst", 1);

    // Full-scale alternating halves force k = 1 into positive saturation
    set_frame(32'h7FFF_FFFF, 32'h8000_0000, 13);
    send_frame(NF);
    check_latency("sat_latency");
    collect("sat", 1);
    check("sat_k1", got[0], 32'h7FFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
